// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
// FAULT state exists only when IFU_MISALIGN_TRAP_EN is defined.
package ifu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1
`ifdef IFU_MISALIGN_TRAP_EN
    , ST_FAULT = 2'd2
`endif
  } ifu_state_e;

endpackage

// File: rtl/ifu_sync_fifo.sv
// rtl/ifu_sync_fifo.sv - synchronous FIFO with clear, count and full/empty flags
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q];
  assign do_push     = push_i & ~full_o & ~clear_i;
  assign do_pop      = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; consumers qualify the head with empty_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, imem request issue, in-order instruction queue, redirect flush
// Optional misaligned-redirect trap (fetch_fault port, FAULT state) under IFU_MISALIGN_TRAP_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
`ifdef IFU_MISALIGN_TRAP_EN
  output logic               fetch_fault,
`endif
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = ADDR_W + INSTR_W;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     q_count, out_cnt;
  logic              q_full, q_empty, tag_full, tag_empty;
  logic [QW-1:0]     q_head;
  logic [ADDR_W-1:0] tag_head, redirect_tgt;
  logic [CW:0]       credit_used;
  logic              accept, q_push, q_pop;

  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);
  // Queued words plus in-flight requests never exceed DEPTH, so responses always fit.
  assign credit_used  = {1'b0, q_count} + {1'b0, out_cnt};
  assign imem_req     = (state_q == ST_RUN) & ~redirect_valid & ~tag_full & (credit_used < DEPTH_W);
  assign imem_addr    = pc_q;
  assign accept       = imem_req & imem_gnt;
  assign q_push       = imem_rvalid & ~tag_empty & ~q_full & (discard_q == '0) & ~redirect_valid;
  assign q_pop        = instr_valid & instr_ready;
  assign instr_valid  = ~q_empty;
  assign instruction  = instr_valid ? q_head[INSTR_W-1:0] : '0;
  assign instr_pc     = instr_valid ? q_head[QW-1:INSTR_W] : '0;

  ifu_sync_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_instr_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (redirect_valid),
    .push_i      (q_push),
    .push_data_i ({tag_head, imem_rdata}),
    .pop_i       (q_pop),
    .head_data_o (q_head),
    .count_o     (q_count),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  // Tag FIFO occupancy doubles as the outstanding-request count.
  ifu_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (1'b0),
    .push_i      (accept),
    .push_data_i (pc_q),
    .pop_i       (imem_rvalid),
    .head_data_o (tag_head),
    .count_o     (out_cnt),
    .full_o      (tag_full),
    .empty_o     (tag_empty)
  );

  always_comb begin
    discard_d = discard_q;
    if (redirect_valid) begin
      discard_d = out_cnt + CW'(accept) - CW'(imem_rvalid);
    end else if (imem_rvalid && discard_q != '0) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_tgt;
    else if (accept)    pc_d = pc_q + ADDR_W'(4);
  end

  always_comb begin
    state_d = fetch_en ? ST_RUN : ST_STOP;
`ifdef IFU_MISALIGN_TRAP_EN
    if (redirect_valid && redirect_pc[1:0] != 2'b00) state_d = ST_FAULT;
    else if (state_q == ST_FAULT && !redirect_valid)  state_d = ST_FAULT;
`endif
  end

`ifdef IFU_MISALIGN_TRAP_EN
  assign fetch_fault = (state_q == ST_FAULT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STOP;
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench for instr_fetch_unit against a queue-level model
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 0, rst_n = 0;
  logic        fetch_en = 0, imem_gnt = 0, imem_rvalid = 0;
  logic        redirect_valid = 0, instr_ready = 0;
  logic [31:0] imem_rdata = 0, redirect_pc = 0;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instruction, instr_pc;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
`ifdef IFU_MISALIGN_TRAP_EN
    .fetch_fault    (fetch_fault),
`endif
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
  );

  int total = 0, bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A00_0013;
  endfunction

  // Model: pending memory requests (stale after a redirect) and delivered-but-unconsumed PCs.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] mq[$];
  logic [31:0] fpc = RESET_PC;
  bit          run_m = 0, fault_m = 0;
  int          cyc = 0;

  int p_gnt = 100, p_ready = 100, p_redir = 0, p_fen = 100, lat_lo = 1, lat_hi = 1;
  bit          force_redir = 0;
  logic [31:0] force_pc = 0;
  int grants = 0, first_grant = -1, first_valid = -1;
  bit          samp_valid, samp_req, samp_acc;
  logic [31:0] samp_pc, samp_addr;

  task automatic step();
    bit acc, pop, rv, rd;
    logic [31:0] rpc;
    pend_t e;
    int lat;
    @(posedge clk);
    #1;
    cyc++;
    samp_valid = instr_valid;
    samp_pc    = instr_pc;
    check_eq("instr_valid", instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check_eq("instr_pc", instr_pc, mq[0]);
      check_eq("instruction", instruction, mem_word(mq[0]));
    end
`ifdef IFU_MISALIGN_TRAP_EN
    check_eq("fetch_fault", fetch_fault, fault_m);
`endif
    if (instr_valid && first_valid < 0) first_valid = cyc;

    fetch_en    = ($urandom_range(99) < p_fen);
    instr_ready = ($urandom_range(99) < p_ready);
    rd  = 0;
    rpc = 0;
    if (force_redir) begin
      rd = 1; rpc = force_pc; force_redir = 0;
    end else if ($urandom_range(999) < p_redir) begin
      rd  = 1;
      rpc = $urandom_range(4095);
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(7) == 0) rpc = 32'hFFFF_FFF8;
    end
    redirect_valid = rd;
    redirect_pc    = rd ? rpc : $urandom;
    rv = (pend.size() != 0) && (pend[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend[0].addr) : $urandom;
    #1;
    samp_req  = imem_req;
    samp_addr = imem_addr;
    check_eq("imem_req", imem_req,
             run_m && !fault_m && !rd && (mq.size() + pend.size() < DEPTH));
    if (imem_req) check_eq("imem_addr", imem_addr, fpc);
    imem_gnt = ($urandom_range(99) < p_gnt);
    acc = imem_req && imem_gnt;
    pop = instr_valid && instr_ready;
    samp_acc = acc;

    if (pop && mq.size() != 0) void'(mq.pop_front());
    if (rv) begin
      e = pend.pop_front();
      if (e.live && !rd) mq.push_back(e.addr);
    end
    if (rd) begin
      mq.delete();
      for (int i = 0; i < pend.size(); i++) pend[i].live = 0;
      fpc = rpc & ~32'h3;
`ifdef IFU_MISALIGN_TRAP_EN
      fault_m = (rpc[1:0] != 2'b00);
`endif
    end
    if (acc) begin
      lat = $urandom_range(lat_hi, lat_lo);
      pend.push_back('{addr: fpc, due: cyc + lat, live: 1'b1});
      fpc = fpc + 32'd4;
      grants++;
      if (first_grant < 0) first_grant = cyc;
    end
    run_m = fetch_en;
  endtask

  task automatic do_reset();
    rst_n = 0;
    fetch_en = 0; imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0; instr_ready = 0;
    force_redir = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    mq.delete(); pend.delete();
    fpc = RESET_PC; run_m = 0; fault_m = 0;
    grants = 0; first_grant = -1; first_valid = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, imem_req, 1'b0);
    check_eq({tag, "_valid"}, instr_valid, 1'b0);
    check_eq({tag, "_instr"}, instruction, 32'h0);
    check_eq({tag, "_pc"}, instr_pc, 32'h0);
    check_eq({tag, "_addr"}, imem_addr, RESET_PC);
`ifdef IFU_MISALIGN_TRAP_EN
    check_eq({tag, "_fault"}, fetch_fault, 1'b0);
`endif
  endtask

  task automatic wait_first_valid(input string tag, input logic [31:0] exp_pc);
    bit found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (samp_valid) found = 1;
    end
    check_eq({tag, "_seen"}, found, 1'b1);
    if (found) check_eq({tag, "_pc"}, samp_pc, exp_pc);
  endtask

  task automatic wait_first_grant(input string tag, input logic [31:0] exp_addr);
    bit found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (samp_acc) found = 1;
    end
    check_eq({tag, "_seen"}, found, 1'b1);
    if (found) check_eq({tag, "_addr"}, samp_addr, exp_addr);
  endtask

  initial begin
    bit found;
    #12;
    check_reset_outputs("por");

    // Streaming with 1-cycle memory and a ready consumer
    do_reset();
    p_gnt = 100; p_ready = 100; p_redir = 0; p_fen = 100; lat_lo = 1; lat_hi = 1;
    repeat (14) step();
    check_eq("first_valid_latency", first_valid - first_grant, 2);

    // Stalled consumer: credit caps grants at DEPTH, then drain in order
    do_reset();
    p_ready = 0;
    repeat (10) step();
    check_eq("stall_grants", grants, DEPTH);
    check_eq("stall_req_low", samp_req, 1'b0);
    p_ready = 100;
    repeat (10) step();

    // Redirect with two requests outstanding
    do_reset();
    lat_lo = 4; lat_hi = 4;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (pend.size() == 2) found = 1;
    end
    check_eq("two_outstanding", found, 1'b1);
    force_redir = 1; force_pc = 32'h100;
    step();
    wait_first_valid("redir_100", 32'h100);

    // Redirect coinciding with a response and a pop
    do_reset();
    lat_lo = 1; lat_hi = 3;
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      step();
      if (mq.size() != 0 && pend.size() != 0 && pend[0].due <= cyc + 1) found = 1;
    end
    check_eq("rv_pop_redirect_found", found, 1'b1);
    force_redir = 1; force_pc = 32'h300;
    step();
    wait_first_valid("redir_300", 32'h300);

    // Random mix: stalls, redirects (incl. wrap target), fetch_en toggling
    p_gnt = 60; p_ready = 70; p_redir = 30; p_fen = 90; lat_lo = 1; lat_hi = 4;
    repeat (3000) step();

    // Asynchronous reset mid-stream
    p_redir = 0; p_fen = 100; p_gnt = 100;
    repeat (5) step();
    #1 rst_n = 0;
    #1 check_reset_outputs("mid_rst");
    do_reset();
    wait_first_grant("post_rst", RESET_PC);

    // Misaligned redirect
    force_redir = 1; force_pc = 32'h102;
    step();
`ifdef IFU_MISALIGN_TRAP_EN
    step();
    check_eq("trap_fault", fetch_fault, 1'b1);
    check_eq("trap_req", samp_req, 1'b0);
    repeat (5) step();
    force_redir = 1; force_pc = 32'h200;
    step();
    wait_first_grant("trap_exit", 32'h200);
`else
    wait_first_grant("mask_low_bits", 32'h100);
`endif
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of the instruction parser.
- Holds the PC and issues word fetches to instruction memory over a request/grant/rvalid handshake.
- Buffers returned words with their PCs in a small in-order queue and presents them downstream with a valid/ready handshake.
- Handles redirects (branch/jump) by flushing the queue and discarding stale in-flight responses.

Parameters:
- ADDR_W, 32, width of PC and imem address
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 2, instruction queue entries; also the maximum outstanding requests (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  permits issue of new requests
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  word-aligned fetch address
- imem_gnt  in  1  request accepted this cycle (when imem_req=1)
- imem_rvalid  in  1  response valid; responses are in order, at least 1 cycle after grant
- imem_rdata  in  32  fetched instruction word
- redirect_valid  in  1  redirect PC this cycle
- redirect_pc  in  ADDR_W  redirect target
- instr_valid  out  1  queue head valid
- instr_ready  in  1  downstream accepts head
- instruction  out  32  head instruction word (feeds the parser's instruction input)
- instr_pc  out  ADDR_W  PC of the head instruction

Behaviour:
- Reset (async assert, sync deassert by the user):
  - pc=RESET_PC; queue empty; outstanding=0; discard_cnt=0; state=STOP.
  - Outputs: imem_req=0, instr_valid=0, instruction=0, instr_pc=0.
- State machine:
  - STOP→RUN when fetch_en=1; RUN→STOP when fetch_en=0 (evaluated each cycle).
  - In STOP no new requests are issued; in-flight responses are still accepted or discarded as normal.
- Issue rule: imem_req=1 iff state==RUN, no redirect this cycle, and (queue_count + outstanding) < DEPTH. imem_addr=pc.
  - Acceptance = imem_req & imem_gnt → pc<=pc+4 and outstanding increments.
  - Request and address must stay stable until granted, except on redirect, where the request is withdrawn.
- Response:
  - imem_rvalid decrements outstanding.
  - If discard_cnt>0, the word is dropped and discard_cnt decrements.
  - Otherwise {pc_of_req, imem_rdata} is pushed. The request PC comes from a DEPTH-entry PC tag FIFO written at grant.
  - Overflow is impossible by the credit rule.
- Output:
  - instr_valid = queue non-empty; instruction/instr_pc come from the head, registered.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle are both honoured.
  - Response to an empty queue appears on instr_valid the next cycle: 1-cycle latency from rvalid.
- Redirect (redirect_valid=1):
  - Effective at that edge: pc<=redirect_pc; queue cleared; instr_valid=0 next cycle.
  - discard_cnt <= all requests still in flight after this edge (outstanding + grant_this_cycle − rvalid_this_cycle).
  - A response arriving in the redirect cycle is dropped.
  - A pop in the redirect cycle counts as consumed.
  - The first request to redirect_pc may issue the following cycle; issue while discard_cnt>0 is permitted.
- Back-to-back redirects: the latest wins; discard_cnt recomputed each time.
- Counters saturate by construction; width is clog2(DEPTH)+1.
- PC wraps modulo 2^ADDR_W.
- imem_addr[1:0] is always 0: redirect_pc[1:0] is forced to 0 unless the optional feature is enabled.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_fault (1 bit) and state FAULT.
  - A redirect with redirect_pc[1:0]≠0 enters FAULT: imem_req=0, fetch_fault=1, queue cleared, discard proceeds.
  - Only a subsequent aligned redirect exits FAULT to RUN (or STOP if fetch_en=0).
  - Reset clears fetch_fault.
- Undefined: no port and no FAULT state; low bits masked silently.

Decomposition:
- Shared package ifu_pkg:
  - state enum (STOP, RUN, FAULT)
  - INSTR_W=32
  - NOP encoding 32'h0000_0013, for benches and downstream bubble insertion
- One natural sub-module: ifu_sync_fifo, parameterised width/depth with push, pop, clear, count, full/empty.
  - Instantiated twice: the instruction queue {pc, instr} and the PC tag FIFO.

Test Plan:
- Reset then fetch_en=1, memory with 1-cycle latency, instr_ready=1:
  - imem_addr sequence 0,4,8,…
  - instr_pc sequence 0,4,8 with instruction=mem[pc]
  - first instr_valid 2 cycles after the first grant.
- instr_ready=0 for 10 cycles:
  - exactly DEPTH=2 grants, then imem_req=0.
  - On release, words drain in order with no loss or duplication.
- Redirect to 0x100 with 2 requests outstanding:
  - both late responses are dropped.
  - next instr_valid shows instr_pc=0x100.
  - no stale PC ever appears.
- Redirect in the same cycle as rvalid and a pop: the response is dropped and discard_cnt equals the remaining in-flight count.
- rst_n asserted mid-stream with requests outstanding: all outputs immediately take reset values and pc=RESET_PC.
- With IFU_MISALIGN_TRAP_EN, redirect to 0x102:
  - fetch_fault=1 and imem_req=0.
  - a later redirect to 0x200 clears the fault and fetch resumes at 0x200.
